// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered
// 8N1 UART receiver with a one-byte holding register and RTS flow control.
// It feeds a register front-end: rxdata/rxrecv form the data/status read
// path, and data_read is that front-end's level "data register being read"
// indication.
//
// Ports
//   clk        in   1  system clock, all logic on posedge
//   rst        in   1  synchronous reset, active-high
//   rx         in   1  asynchronous serial line, idle high
//   data_read  in   1  level: holding byte is being read (may last many clocks)
//   rxdata     out  8  holding register, last received byte
//   rxrecv     out  1  holding register full
//   frame_err  out  1  sticky: a stop bit was sampled low
//   overrun    out  1  sticky: a byte was dropped because holding was full
//   rts        out  1  1 = remote must pause (holding full or in reset)
//   dbg_state  out  2  receive FSM state (0 idle, 1 start, 2 data, 3 stop)
//
// Read handshake: rxrecv acts as "valid" for rxdata. The reader holds
// data_read high for as long as it likes; rxdata never changes because of
// the read itself. The byte is consumed on the falling edge of data_read,
// which clears rxrecv together with the sticky error flags. A byte that
// completes while rxrecv is still set is dropped and flagged as overrun.

module uart_rx_buffered #(
    parameter int CLK = 28000000,
    parameter int BPS = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       data_read,
    output logic [7:0] rxdata,
    output logic       rxrecv,
    output logic       frame_err,
    output logic       overrun,
    output logic       rts,
    output logic [1:0] dbg_state
);

    localparam int DIV  = CLK / BPS;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);

    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [1:0]    rx_sync_q;
    logic [1:0]    fill_q;
    logic          armed_q, armed_d;
    logic          dr_q;
    logic [7:0]    rxdata_q, rxdata_d;
    logic          rxrecv_q, rxrecv_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic          rts_q;

    logic rx_s;
    logic deliver;
    logic stop_bad;
    logic consume;

    assign rx_s    = rx_sync_q[1];
    assign consume = dr_q & ~data_read;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bitcnt_d    = bitcnt_q;
        shreg_d     = shreg_q;
        armed_d     = armed_q;
        rxdata_d    = rxdata_q;
        rxrecv_d    = rxrecv_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;
        deliver     = 1'b0;
        stop_bad    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (armed_q && !rx_s) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d  = S_DATA;
                        bitcnt_d = 3'd0;
                    end else begin
                        // Line returned high before mid start bit: glitch.
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == DIV_M1) begin
                    cnt_d   = '0;
                    // LSB arrives first, so shift in at the top.
                    shreg_d = {rx_s, shreg_q[7:1]};
                    if (bitcnt_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == DIV_M1) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (rx_s) begin
                        deliver = 1'b1;
                    end else begin
                        stop_bad = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Re-arm only once the synchroniser carries real line data; its
        // reset value of 1 would otherwise arm on a line that is held low
        // through reset and let a mid-frame low look like a start bit.
        if (stop_bad) begin
            armed_d = 1'b0;
        end else if (rx_s && fill_q[1]) begin
            armed_d = 1'b1;
        end

        // Consume is applied before a same-cycle load, so a byte that lands
        // exactly as the previous one is consumed is kept, not overrun.
        if (consume) begin
            rxrecv_d    = 1'b0;
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
        end
        if (deliver) begin
            if (!rxrecv_d) begin
                rxdata_d = shreg_q;
                rxrecv_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
        if (stop_bad) begin
            frame_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bitcnt_q    <= 3'd0;
            shreg_q     <= 8'd0;
            rx_sync_q   <= 2'b11;
            fill_q      <= 2'b00;
            armed_q     <= 1'b0;
            dr_q        <= 1'b0;
            rxdata_q    <= 8'd0;
            rxrecv_q    <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            rts_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            rx_sync_q   <= {rx_sync_q[0], rx};
            fill_q      <= {fill_q[0], 1'b1};
            armed_q     <= armed_d;
            dr_q        <= data_read;
            rxdata_q    <= rxdata_d;
            rxrecv_q    <= rxrecv_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            rts_q       <= rxrecv_q;
        end
    end

    assign rxdata    = rxdata_q;
    assign rxrecv    = rxrecv_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign rts       = rts_q;
    assign dbg_state = state_q;

endmodule
